// File: rtl/loopback_run_ctrl.sv
// Run controller for the loopback index engine: turns one `go` into num_iter back-to-back
// engine runs (reset, start pulse, wait for sticky finish) with a per-run watchdog.
module loopback_run_ctrl #(
    parameter int unsigned NUM_ITER_WIDTH  = 16,
    parameter int unsigned CYCLE_CNT_WIDTH = 32,
    parameter int unsigned CLEAR_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1048576
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       go,
    input  logic                       abort,
    input  logic [NUM_ITER_WIDTH-1:0]  num_iter,
    input  logic                       engine_finish,
    output logic                       engine_reset,
    output logic                       engine_start,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout,
    output logic                       aborted,
    output logic [NUM_ITER_WIDTH-1:0]  iter_count,
    output logic [CYCLE_CNT_WIDTH-1:0] cycle_count
);

    localparam int unsigned CLR_W  = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(CLEAR_CYCLES - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStart,
        StWait,
        StDone
    } state_t;

    state_t                     r_state;
    logic [CLR_W-1:0]           r_clr_cnt;
    logic [WDOG_W-1:0]          r_wdog;
    logic [NUM_ITER_WIDTH-1:0]  r_num_iter;
    logic [NUM_ITER_WIDTH-1:0]  r_iter_count;
    logic [CYCLE_CNT_WIDTH-1:0] r_cycle_count;
    logic                       r_engine_reset;
    logic                       r_engine_start;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_timeout;
    logic                       r_aborted;

    state_t                     w_state_d;
    logic                       w_accept;
    logic                       w_running;
    logic                       w_counting;
    logic                       w_finish_ok;
    logic                       w_wdog_fire;
    logic [NUM_ITER_WIDTH-1:0]  w_iter_inc;

    assign w_running  = (r_state == StClear) || (r_state == StStart) || (r_state == StWait);
    assign w_counting = (r_state == StStart) || (r_state == StWait);
    assign w_accept   = ((r_state == StIdle) || (r_state == StDone)) && go && !abort;
    assign w_iter_inc = r_iter_count + 1'b1;

    // abort beats finish, finish beats the watchdog
    assign w_finish_ok = (r_state == StWait) && !abort && engine_finish;
    assign w_wdog_fire = (r_state == StWait) && !abort && !engine_finish && (r_wdog == WDOG_LAST);

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle, StDone: begin
                if (w_accept) begin
                    w_state_d = (num_iter == '0) ? StDone : StClear;
                end
            end
            StClear: begin
                if (abort) begin
                    w_state_d = StDone;
                end else if (r_clr_cnt == CLR_LAST) begin
                    w_state_d = StStart;
                end
            end
            StStart: begin
                w_state_d = abort ? StDone : StWait;
            end
            StWait: begin
                if (abort) begin
                    w_state_d = StDone;
                end else if (engine_finish) begin
                    w_state_d = (w_iter_inc == r_num_iter) ? StDone : StClear;
                end else if (r_wdog == WDOG_LAST) begin
                    w_state_d = StDone;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= StIdle;
            r_clr_cnt      <= '0;
            r_wdog         <= '0;
            r_num_iter     <= '0;
            r_iter_count   <= '0;
            r_cycle_count  <= '0;
            r_engine_reset <= 1'b1;
            r_engine_start <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_timeout      <= 1'b0;
            r_aborted      <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_engine_reset <= !((w_state_d == StStart) || (w_state_d == StWait));
            r_engine_start <= (w_state_d == StStart);
            r_busy         <= (w_state_d == StClear) || (w_state_d == StStart) ||
                              (w_state_d == StWait);
            r_done         <= (w_state_d == StDone);

            r_clr_cnt <= (r_state == StClear) ? r_clr_cnt + 1'b1 : '0;
            r_wdog    <= (r_state == StWait) ? r_wdog + 1'b1 : '0;

            if (w_accept) begin
                r_num_iter    <= num_iter;
                r_iter_count  <= '0;
                r_cycle_count <= '0;
                r_timeout     <= 1'b0;
                r_aborted     <= 1'b0;
            end else begin
                if (w_counting && (r_cycle_count != '1)) begin
                    r_cycle_count <= r_cycle_count + 1'b1;
                end
                if (w_finish_ok) begin
                    r_iter_count <= w_iter_inc;
                end
                if (w_wdog_fire) begin
                    r_timeout <= 1'b1;
                end
                if (w_running && abort) begin
                    r_aborted <= 1'b1;
                end
            end
        end
    end

    assign engine_reset = r_engine_reset;
    assign engine_start = r_engine_start;
    assign busy         = r_busy;
    assign done         = r_done;
    assign timeout      = r_timeout;
    assign aborted      = r_aborted;
    assign iter_count   = r_iter_count;
    assign cycle_count  = r_cycle_count;

endmodule

// File: doc/loopback_run_ctrl.md
# loopback_run_ctrl

Run controller that sits directly upstream of the loopback index engine. It turns a single CSR `go` into one or more back-to-back engine runs. For each run it holds the engine in reset, pulses its `start`, and waits for its sticky `finish`. It also counts iterations and cycles, enforces a per-run watchdog, and reports `done`/status back to the CSR layer.

## Interface
- `NUM_ITER_WIDTH`, 16: width of the iteration-count request and status.
- `CYCLE_CNT_WIDTH`, 32: width of the total cycle counter.
- `CLEAR_CYCLES`, 4: cycles the engine is held in reset before each start; must be ≥1.
- `TIMEOUT_CYCLES`, 1048576: maximum WAIT cycles per run before timeout; must be ≥2.

Ports:
- `clk` in 1: single clock for the whole block.
- `reset_n` in 1: asynchronous, active-low reset.
- `go` in 1: run request; sampled only in IDLE or DONE.
- `abort` in 1: cancel the current run; level-sampled every cycle.
- `num_iter` in NUM_ITER_WIDTH: number of runs; latched when `go` is accepted.
- `engine_finish` in 1: sticky finish flag from the engine.
- `engine_reset` out 1: active-high reset to the engine.
- `engine_start` out 1: one-cycle start pulse to the engine.
- `busy` out 1: high in CLEAR, START and WAIT.
- `done` out 1: high in DONE.
- `timeout` out 1: status bit; the last command ended by watchdog.
- `aborted` out 1: status bit; the last command ended by `abort`.
- `iter_count` out NUM_ITER_WIDTH: number of runs completed.
- `cycle_count` out CYCLE_CNT_WIDTH: total cycles spent in START+WAIT; saturating.

## Operation
- States: IDLE, CLEAR, START, WAIT, DONE. All outputs are Moore outputs decoded from registered state or held in registers.
- `engine_reset` = 1 in IDLE, CLEAR and DONE; 0 in START and WAIT. The engine is therefore held in reset whenever it is not running, which also clears its sticky `finish`.
- `engine_start` = 1 only in START.
- **IDLE or DONE, `go` = 1 and `abort` = 0:**
  - Latch `num_iter`.
  - Clear `iter_count`, `cycle_count`, `timeout` and `aborted`.
  - If the latched value is 0, go to DONE with all counts at 0. Otherwise go to CLEAR.
- **CLEAR:** the clear counter runs 0..CLEAR_CYCLES-1, then the block goes to START.
- **START:** exactly one cycle, then WAIT. The watchdog is cleared on entry to WAIT.
- **WAIT, `engine_finish` = 1:**
  - `iter_count` increments.
  - If the new value equals the latched `num_iter`, go to DONE. Otherwise go to CLEAR.
- **WAIT, `engine_finish` = 0 and watchdog == TIMEOUT_CYCLES-1:** set `timeout` and go to DONE; `iter_count` is not incremented.
- **`abort` = 1 in CLEAR, START or WAIT:** set `aborted` and go to DONE next cycle. In IDLE or DONE, `abort` has no effect except to block `go`.
- **`cycle_count`:** increments on every cycle in START or WAIT and saturates at all-ones.
- **Simultaneous events:**
  - `abort` wins over `engine_finish` and over timeout; `iter_count` is not incremented.
  - `engine_finish` wins over timeout.
  - `abort` wins over `go`.
- **`go` while busy:** ignored; no queuing.
- **`engine_finish` outside WAIT:** ignored.

## Timing
- **Reset values:**
  - State is IDLE.
  - `engine_reset` = 1.
  - `engine_start`, `busy`, `done`, `timeout`, `aborted` = 0.
  - `iter_count`, `cycle_count` = 0.
- **Reset mid-operation:** `reset_n` low forces the reset values immediately (asynchronous). `engine_reset` rises without waiting for a clock edge.
- **Accept latency:** `go` sampled at edge T makes `busy` = 1 from T+1. `engine_start` is high in cycle T+1+CLEAR_CYCLES.
- **Gap between runs:** `engine_finish` sampled in WAIT at edge t leads to CLEAR from t+1. The next `engine_start` is at t+1+CLEAR_CYCLES. Total dead time between runs is CLEAR_CYCLES+1 cycles.
- **Completion:** `done` rises one cycle after the final `engine_finish`. It stays high until the next accepted `go`, and falls in the cycle `busy` rises.
- **Timeout:** fires on the TIMEOUT_CYCLES-th WAIT cycle without `engine_finish`.
- **Watchdog width:** $clog2(TIMEOUT_CYCLES).

## Test plan
- `num_iter` = 1, engine model asserts `finish` 10 cycles after `start` -> `engine_start` 4 cycles after `go` is accepted; `done` = 1, `iter_count` = 1, `cycle_count` = 11, `timeout` = 0.
- `num_iter` = 3, finish latency 10 -> exactly three `engine_start` pulses spaced 15 cycles apart; `engine_reset` = 1 for 4 cycles before each; `iter_count` = 3.
- `num_iter` = 0 -> `done` one cycle after `go`; no `engine_start`; all counts 0.
- `TIMEOUT_CYCLES` = 16, engine never finishes -> `done` with `timeout` = 1, `iter_count` = 0, `cycle_count` = 17.
- `abort` asserted in the same cycle as `engine_finish` during iteration 2 of 3 -> `aborted` = 1, `iter_count` = 1, `engine_reset` = 1 next cycle. A `go` pulsed while `busy` has no effect.
- `reset_n` pulsed low during WAIT -> all outputs return to their reset values asynchronously. A following `go` with `num_iter` = 1 completes normally.
